// File: rtl/wb_csr_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// wb_csr_ctrl_pkg
// Shared definitions for the writeback-stage CSR controller:
//   - exception codes (ecode) used on wb_ecode
//   - CSR numbers of the architectural CSR file
//   - bit positions inside the ms_op / ms_exc class vectors
//   - the packed WB stage payload and a small op-decoding helper
// ----------------------------------------------------------------------------
package wb_csr_ctrl_pkg;

    // Exception codes
    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    // CSR numbers
    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;

    // ms_op bit positions: {ertn, csrxchg, csrwr, csrrd}
    localparam int OP_CSRRD   = 0;
    localparam int OP_CSRWR   = 1;
    localparam int OP_CSRXCHG = 2;
    localparam int OP_ERTN    = 3;

    // ms_exc bit positions: {adef, ine, syscall, brk, ale}
    localparam int EXC_ALE  = 0;
    localparam int EXC_BRK  = 1;
    localparam int EXC_SYS  = 2;
    localparam int EXC_INE  = 3;
    localparam int EXC_ADEF = 4;

    // Instruction state held by the WB stage register
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] vaddr;
        logic [3:0]  op;
        logic [4:0]  exc;
        logic [13:0] csr_num;
        logic [31:0] rj_val;
        logic [31:0] rd_val;
        logic [4:0]  dest;
        logic [31:0] res;
        logic        gr_we;
    } ws_payload_t;

    // True for the ops whose regfile result is the old CSR value
    function automatic logic is_csr_access(input logic [3:0] op);
        return op[OP_CSRRD] | op[OP_CSRWR] | op[OP_CSRXCHG];
    endfunction

endpackage

// File: rtl/wb_csr_ctrl_if.sv
// ----------------------------------------------------------------------------
// wb_csr_ctrl_if
// MEM -> WB instruction bus. The MEM stage (master) offers an instruction
// with ms_to_ws_valid plus its payload; the WB stage (slave) answers with
// ws_allowin.
// ----------------------------------------------------------------------------
interface wb_csr_ctrl_if;

    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic [31:0] ms_vaddr;
    logic [3:0]  ms_op;
    logic [4:0]  ms_exc;
    logic [13:0] ms_csr_num;
    logic [31:0] ms_rj_val;
    logic [31:0] ms_rd_val;
    logic [4:0]  ms_dest;
    logic [31:0] ms_res;
    logic        ms_gr_we;

    modport master (
        output ms_to_ws_valid, ms_pc, ms_vaddr, ms_op, ms_exc, ms_csr_num,
               ms_rj_val, ms_rd_val, ms_dest, ms_res, ms_gr_we,
        input  ws_allowin
    );

    modport slave (
        input  ms_to_ws_valid, ms_pc, ms_vaddr, ms_op, ms_exc, ms_csr_num,
               ms_rj_val, ms_rd_val, ms_dest, ms_res, ms_gr_we,
        output ws_allowin
    );

endinterface

// File: rtl/wb_exc_prio.sv
// ----------------------------------------------------------------------------
// wb_exc_prio
// Combinational exception priority encoder.
//   has_int : pending enabled interrupt (highest priority)
//   exc     : {adef, ine, syscall, brk, ale} flags of the instruction
//   ex      : some exception is taken
//   ecode   : code of the winning exception (INT_ECODE when nothing is taken)
// Priority: interrupt > adef > ine > syscall > brk > ale.
// ----------------------------------------------------------------------------
module wb_exc_prio
    import wb_csr_ctrl_pkg::*;
#(
    parameter logic [5:0] INT_ECODE = ECODE_INT
) (
    input  logic       has_int,
    input  logic [4:0] exc,
    output logic       ex,
    output logic [5:0] ecode
);

    always_comb begin
        ex    = has_int | (|exc);
        ecode = INT_ECODE;
        if (!has_int) begin
            if (exc[EXC_ADEF]) begin
                ecode = ECODE_ADEF;
            end else if (exc[EXC_INE]) begin
                ecode = ECODE_INE;
            end else if (exc[EXC_SYS]) begin
                ecode = ECODE_SYS;
            end else if (exc[EXC_BRK]) begin
                ecode = ECODE_BRK;
            end else if (exc[EXC_ALE]) begin
                ecode = ECODE_ALE;
            end
        end
    end

endmodule

// File: rtl/wb_csr_ctrl.sv
// ----------------------------------------------------------------------------
// wb_csr_ctrl
// Writeback stage initiator for the CSR register file.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   ms (slave)        : MEM -> WB instruction bus, ws_allowin back to MEM
//   csr_re/num/we/wmask/wvalue, csr_rvalue, csr_eentry : CSR file port
//   has_int           : pending enabled interrupt, sampled at commit
//   wb_ex/ecode/esubcode/pc/vaddr, ertn_flush : exception / return commit
//   rf_we/waddr/wdata : regfile write port
//   redirect_valid/target/ready : front-end redirect handshake to IF
// An instruction commits in the cycle it sits in WB while the stage is in
// RUN. An exception or ERTN moves the stage to REDIRECT, where the redirect
// request is held and every instruction delivered by MEM is dropped until IF
// accepts the redirect.
// ----------------------------------------------------------------------------
module wb_csr_ctrl
    import wb_csr_ctrl_pkg::*;
#(
    parameter logic [13:0] CSR_ERA_NUM = CSR_ERA,
    parameter logic [5:0]  INT_ECODE   = ECODE_INT
) (
    input  logic              clk,
    input  logic              reset,

    wb_csr_ctrl_if.slave      ms,

    output logic              csr_re,
    output logic [13:0]       csr_num,
    output logic              csr_we,
    output logic [31:0]       csr_wmask,
    output logic [31:0]       csr_wvalue,
    input  logic [31:0]       csr_rvalue,
    input  logic [31:0]       csr_eentry,
    input  logic              has_int,

    output logic              wb_ex,
    output logic [5:0]        wb_ecode,
    output logic [8:0]        wb_esubcode,
    output logic [31:0]       wb_pc,
    output logic [31:0]       wb_vaddr,
    output logic              ertn_flush,

    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       rf_wdata,

    output logic              redirect_valid,
    output logic [31:0]       redirect_target,
    input  logic              redirect_ready
);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_REDIRECT = 1'b1;

    logic [0:0]  state_reg, state_next;
    logic        ws_valid_reg, ws_valid_next;
    ws_payload_t ws_reg;
    ws_payload_t ms_payload;
    logic        redirect_valid_reg, redirect_valid_next;
    logic [31:0] redirect_target_reg, redirect_target_next;

    logic        ms_accept;
    logic        commit;
    logic        prio_ex;
    logic [5:0]  prio_ecode;
    logic        op_ertn;
    logic        op_wr_any;
    logic        go_redirect;

    assign ms_payload = '{
        pc:      ms.ms_pc,
        vaddr:   ms.ms_vaddr,
        op:      ms.ms_op,
        exc:     ms.ms_exc,
        csr_num: ms.ms_csr_num,
        rj_val:  ms.ms_rj_val,
        rd_val:  ms.ms_rd_val,
        dest:    ms.ms_dest,
        res:     ms.ms_res,
        gr_we:   ms.ms_gr_we
    };

    // Both states accept; REDIRECT simply throws the instruction away.
    assign ms.ws_allowin = (state_reg == ST_RUN) || (state_reg == ST_REDIRECT);
    assign ms_accept     = ms.ms_to_ws_valid && ms.ws_allowin;

    assign commit    = ws_valid_reg && (state_reg == ST_RUN);
    assign op_ertn   = ws_reg.op[OP_ERTN];
    assign op_wr_any = ws_reg.op[OP_CSRWR] | ws_reg.op[OP_CSRXCHG];

    wb_exc_prio #(
        .INT_ECODE (INT_ECODE)
    ) u_exc_prio (
        .has_int (has_int),
        .exc     (ws_reg.exc),
        .ex      (prio_ex),
        .ecode   (prio_ecode)
    );

    // Exception commit
    assign wb_ex       = commit && prio_ex;
    assign wb_ecode    = prio_ecode;
    assign wb_esubcode = 9'd0;
    assign wb_pc       = ws_reg.pc;
    assign wb_vaddr    = ws_reg.vaddr;
    assign ertn_flush  = commit && op_ertn && !prio_ex;

    // CSR port; ERTN reads ERA to find its return address
    assign csr_num    = op_ertn ? CSR_ERA_NUM : ws_reg.csr_num;
    assign csr_re     = commit && (|ws_reg.op);
    assign csr_we     = commit && !prio_ex && op_wr_any;
    assign csr_wmask  = ws_reg.op[OP_CSRXCHG] ? ws_reg.rj_val : 32'hFFFF_FFFF;
    assign csr_wvalue = ws_reg.rd_val;

    // Regfile port; CSR ops return the value read before this cycle's write
    assign rf_we    = commit && !prio_ex && ws_reg.gr_we;
    assign rf_waddr = ws_reg.dest;
    assign rf_wdata = is_csr_access(ws_reg.op) ? csr_rvalue : ws_reg.res;

    assign go_redirect = wb_ex || ertn_flush;

    assign redirect_valid  = redirect_valid_reg;
    assign redirect_target = redirect_target_reg;

    // An instruction arriving next to a redirecting one is younger and dropped.
    assign ws_valid_next = ms_accept && (state_reg == ST_RUN) && !go_redirect;

    always_comb begin
        state_next           = state_reg;
        redirect_valid_next  = redirect_valid_reg;
        redirect_target_next = redirect_target_reg;
        case (state_reg)
            ST_RUN: begin
                if (go_redirect) begin
                    state_next           = ST_REDIRECT;
                    redirect_valid_next  = 1'b1;
                    redirect_target_next = wb_ex ? csr_eentry : csr_rvalue;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_next          = ST_RUN;
                    redirect_valid_next = 1'b0;
                end
            end
            default: begin
                state_next          = ST_RUN;
                redirect_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg           <= ST_RUN;
            ws_valid_reg        <= 1'b0;
            ws_reg              <= '0;
            redirect_valid_reg  <= 1'b0;
            redirect_target_reg <= 32'd0;
        end else begin
            state_reg           <= state_next;
            ws_valid_reg        <= ws_valid_next;
            redirect_valid_reg  <= redirect_valid_next;
            redirect_target_reg <= redirect_target_next;
            if (ms_accept) begin
                ws_reg <= ms_payload;
            end
        end
    end

endmodule

// File: doc/wb_csr_ctrl.md
Name: wb_csr_ctrl

Overview:
- Writeback-stage initiator for the CSR register file: captures the instruction leaving MEM and drives the CSR read/write port and exception signals (wb_ex/ecode/esubcode/pc/vaddr, ertn_flush).
- Returns the old CSR value to the regfile and samples has_int.
- Issues a front-end redirect (exception entry or ERTN return) through a valid/ready handshake.
- Sits between the MEM stage, the CSR file and the IF stage.

Parameters:
CSR_ERA_NUM, 14'h006, CSR number read to obtain the ERTN return address
INT_ECODE, 6'h00, ecode used when an interrupt is taken

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high
ms_to_ws_valid  in  1  MEM stage offers an instruction
ws_allowin  out  1  WB accepts an instruction this cycle
ms_pc  in  32  instruction PC
ms_vaddr  in  32  load/store address
ms_op  in  4  one-hot-ish class: {ertn, csrxchg, csrwr, csrrd}
ms_exc  in  5  {adef, ine, syscall, brk, ale} flags
ms_csr_num  in  14  CSR number
ms_rj_val  in  32  csrxchg mask
ms_rd_val  in  32  CSR write data
ms_dest  in  5  regfile destination
ms_res  in  32  non-CSR result
ms_gr_we  in  1  instruction writes regfile
csr_re  out  1  CSR read enable
csr_num  out  14  CSR number
csr_we  out  1  CSR write enable
csr_wmask  out  32  write mask
csr_wvalue  out  32  write value
csr_rvalue  in  32  combinational CSR read data
csr_eentry  in  32  exception entry
has_int  in  1  pending enabled interrupt
wb_ex  out  1  exception commit pulse
wb_ecode  out  6  ecode
wb_esubcode  out  9  esubcode (always 0)
wb_pc  out  32  faulting PC
wb_vaddr  out  32  faulting address
ertn_flush  out  1  ERTN commit pulse
rf_we  out  1  regfile write enable
rf_waddr  out  5  regfile write address
rf_wdata  out  32  regfile write data
redirect_valid  out  1  redirect request to IF
redirect_target  out  32  redirect PC
redirect_ready  in  1  IF accepts the redirect

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous, active-high.
- Reset values: ws_valid=0, state=RUN, redirect_valid=0, redirect_target=0, every WB payload register=0.
- Consequence of reset: all commit outputs (csr_we, wb_ex, ertn_flush, rf_we) are 0.
- Stage register: captures the ms_* inputs when ms_to_ws_valid && ws_allowin.
- ws_allowin: 1 in RUN and REDIRECT. There is no internal stall.
- Commit timing: commit happens in the cycle the instruction occupies WB (ws_valid=1), with state=RUN. Side effects go out combinationally in that cycle and take effect at the next edge.

Exception select (commit cycle), priority order:
- has_int: ecode 0x00
- adef: 0x08
- ine: 0x0D
- syscall: 0x0B
- brk: 0x0C
- ale: 0x09
- Any of the above present: wb_ex=1, wb_pc=ws_pc, wb_vaddr=ws_vaddr, wb_esubcode=0.

CSR port:
- csr_num = ertn ? CSR_ERA_NUM : ws_csr_num.
- csr_re = commit && (csrrd|csrwr|csrxchg|ertn).
- csr_we = commit && !ex && (csrwr|csrxchg).
- csr_wmask = csrxchg ? ws_rj_val : 32'hFFFFFFFF.
- csr_wvalue = ws_rd_val.

Regfile port:
- rf_we = commit && !ex && ws_gr_we.
- rf_wdata = csr op ? csr_rvalue (pre-write old value) : ws_res.

ERTN:
- ertn_flush = commit && ertn && !ex.

State machine:
- RUN: on wb_ex or ertn_flush, go to REDIRECT.
  - Register redirect_target = wb_ex ? csr_eentry : csr_rvalue (ERA).
  - Register redirect_valid=1.
- REDIRECT:
  - redirect_valid held, redirect_target stable.
  - Incoming instructions are accepted and discarded: ws_valid is cleared and no commit occurs.
  - When redirect_ready=1: redirect_valid=0 and state=RUN at the next edge. Instructions arriving in that same cycle are also discarded.
- Reset in any state: returns to RUN and drops redirect_valid.

Invariants:
- wb_ex and ertn_flush are never both 1.
- Each pulses for exactly one cycle per committed instruction.
- An instruction with an exception never writes a CSR or the regfile.

Decomposition:
- Shared package holds:
  - ecode constants: INT, ADEF, ALE, SYS, BRK, INE.
  - CSR number constants: CRMD, PRMD, ESTAT, ERA, EENTRY, …
  - the ms_op/ms_exc bit-index constants.
- Natural sub-module: wb_exc_prio, a combinational priority encoder from (has_int, ms_exc) to (ex, ecode).

Test Plan:
- csrwr, csr_num=0x30, rd_val=0x12345678, CSR returns 0xAAAA0000 -> csr_we=1, wmask=FFFFFFFF, wvalue=0x12345678; rf_we=1, rf_wdata=0xAAAA0000; no redirect.
- csrxchg, rj_val=0x0000FF00, rd_val=0xFFFFFFFF, csr_num=0x4 -> csr_wmask=0x0000FF00, wvalue=0xFFFFFFFF, csr_we=1.
- syscall at pc=0x1C000100, csr_eentry=0x1C008000 -> wb_ex=1 for 1 cycle, ecode=0x0B, wb_pc=0x1C000100; next cycle redirect_valid=1, target=0x1C008000; younger instructions discarded until redirect_ready.
- ertn, csr_rvalue(ERA)=0x1C000104 -> csr_num=0x006, ertn_flush=1, wb_ex=0; target=0x1C000104. Hold redirect_ready=0 for 3 cycles -> valid and target stable throughout.
- has_int=1 together with an ale instruction and csrwr -> ecode=0x00, csr_we=0, rf_we=0.
- Reset asserted while in REDIRECT -> next cycle redirect_valid=0, state RUN, the following instruction commits normally.
